// File: rtl/ram_bus_arbiter.sv
// Two-master arbiter for the single-port synchronous data RAM: the CPU has fixed priority,
// and a starvation counter forces a DMA grant. Only one access is in flight at a time.
module ram_bus_arbiter #(
    parameter int ADDR_WIDTH   = 16,
    parameter int DATA_WIDTH   = 8,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    // CPU requester
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    output logic                  cpu_gnt,
    output logic                  cpu_rvalid,
    output logic [DATA_WIDTH-1:0] cpu_rdata,
    // DMA requester
    input  logic                  dma_req,
    input  logic                  dma_we,
    input  logic [ADDR_WIDTH-1:0] dma_addr,
    input  logic [DATA_WIDTH-1:0] dma_wdata,
    output logic                  dma_gnt,
    output logic                  dma_rvalid,
    output logic [DATA_WIDTH-1:0] dma_rdata,
    // RAM side
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  owner_o
);

    localparam int CNT_W = 4;
    localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    state_t state_q, state_d;

    // Requester index 0 is the CPU, index 1 is the DMA engine.
    logic [1:0]            req_vec;
    logic [1:0]            we_vec;
    logic [ADDR_WIDTH-1:0] addr_vec  [2];
    logic [DATA_WIDTH-1:0] wdata_vec [2];

    assign req_vec      = {dma_req, cpu_req};
    assign we_vec       = {dma_we, cpu_we};
    assign addr_vec[0]  = cpu_addr;
    assign addr_vec[1]  = dma_addr;
    assign wdata_vec[0] = cpu_wdata;
    assign wdata_vec[1] = dma_wdata;

    logic                  mem_en_q,    mem_en_d;
    logic                  mem_we_q,    mem_we_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q,  mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
    logic                  owner_q,     owner_d;
    logic [1:0]            gnt_q,       gnt_d;
    logic [1:0]            rvalid_q,    rvalid_d;
    logic [CNT_W-1:0]      starve_cnt_q, starve_cnt_d;

    logic arb_edge;
    logic starve_full;
    logic dma_win;
    logic cpu_win;
    logic win_idx;
    logic access_read;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:   if (|req_vec) state_d = ST_ACCESS;
            ST_ACCESS: state_d = ST_RESP;
            ST_RESP:   state_d = (|req_vec) ? ST_ACCESS : ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Arbitration: evaluated on every edge leaving IDLE or RESP
    // ------------------------------------------------------------------
    always_comb begin
        arb_edge    = (state_q == ST_IDLE) || (state_q == ST_RESP);
        starve_full = (starve_cnt_q == STARVE_MAX);
        dma_win     = arb_edge && dma_req && (!cpu_req || starve_full);
        cpu_win     = arb_edge && cpu_req && !dma_win;
        win_idx     = dma_win;
    end

    // ------------------------------------------------------------------
    // Output / datapath next values
    // ------------------------------------------------------------------
    always_comb begin
        mem_en_d    = 1'b0;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        owner_d     = owner_q;
        gnt_d       = 2'b00;
        if (cpu_win || dma_win) begin
            mem_en_d    = 1'b1;
            mem_we_d    = we_vec[win_idx];
            mem_addr_d  = addr_vec[win_idx];
            mem_wdata_d = wdata_vec[win_idx];
            owner_d     = win_idx;
            gnt_d       = {dma_win, cpu_win};
        end
    end

    // Read data arrives the cycle after ACCESS, so rvalid is registered off the ACCESS state.
    assign access_read = (state_q == ST_ACCESS) && !mem_we_q;

    for (genvar gi = 0; gi < 2; gi++) begin : g_rvalid
        assign rvalid_d[gi] = access_read && (owner_q == 1'(gi));
    end

    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (arb_edge) begin
            if (dma_win || !dma_req) begin
                starve_cnt_d = '0;
            end else if (cpu_win && !starve_full) begin
                starve_cnt_d = starve_cnt_q + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            owner_q      <= 1'b0;
            gnt_q        <= 2'b00;
            rvalid_q     <= 2'b00;
            starve_cnt_q <= '0;
        end else begin
            mem_en_q     <= mem_en_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            owner_q      <= owner_d;
            gnt_q        <= gnt_d;
            rvalid_q     <= rvalid_d;
            starve_cnt_q <= starve_cnt_d;
        end
    end

    assign mem_en     = mem_en_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign owner_o    = owner_q;
    assign cpu_gnt    = gnt_q[0];
    assign dma_gnt    = gnt_q[1];
    assign cpu_rvalid = rvalid_q[0];
    assign dma_rvalid = rvalid_q[1];
    assign cpu_rdata  = mem_rdata;
    assign dma_rdata  = mem_rdata;

endmodule

// File: tb/tb_ram_bus_arbiter.sv
// Bench for ram_bus_arbiter: table of single transactions, a read-data scoreboard, and
// hand-written sequences for contention, starvation and mid-operation reset.
module tb_ram_bus_arbiter;

    localparam int AW = 16;
    localparam int DW = 8;
    localparam int SL = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          cpu_req, cpu_we, cpu_gnt, cpu_rvalid;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata, cpu_rdata;
    logic          dma_req, dma_we, dma_gnt, dma_rvalid;
    logic [AW-1:0] dma_addr;
    logic [DW-1:0] dma_wdata, dma_rdata;
    logic          mem_en, mem_we, owner_o;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;

    always #5 clk = ~clk;

    ram_bus_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STARVE_LIMIT(SL)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .owner_o(owner_o)
    );

    // Synchronous RAM with a side loader port for preloading contents.
    logic [DW-1:0] ram [0:65535];
    logic          ld_en;
    logic [AW-1:0] ld_addr;
    logic [DW-1:0] ld_data;

    always @(posedge clk) begin
        if (ld_en) ram[ld_addr] <= ld_data;
        if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        mem_rdata <= ram[mem_addr];
        end
    end

    int checks_total  = 0;
    int checks_passed = 0;

    logic [DW-1:0] cpu_sb[$];
    logic [DW-1:0] dma_sb[$];
    bit            gnt_log[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks_total++;
        if (act === exp) checks_passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Monitor: grant exclusivity, grant order log, read data against the scoreboard.
    always begin
        @(posedge clk);
        #2;
        if (!reset) begin
            if (cpu_gnt || dma_gnt) begin
                check("gnt_exclusive", 32'(cpu_gnt & dma_gnt), 32'd0);
                gnt_log.push_back(dma_gnt);
            end
            if (cpu_rvalid && dma_rvalid) check("rvalid_exclusive", 32'd1, 32'd0);
            if (cpu_rvalid) begin
                if (cpu_sb.size() == 0) check("cpu_rvalid_spurious", 32'd1, 32'd0);
                else                    check("cpu_rdata", 32'(cpu_rdata), 32'(cpu_sb.pop_front()));
            end
            if (dma_rvalid) begin
                if (dma_sb.size() == 0) check("dma_rvalid_spurious", 32'd1, 32'd0);
                else                    check("dma_rdata", 32'(dma_rdata), 32'(dma_sb.pop_front()));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    typedef struct packed {
        logic          is_dma;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] exp_rdata;
    } vec_t;

    vec_t vecs [8];

    task automatic drive_req(input logic is_dma, input logic we, input logic [AW-1:0] addr,
                             input logic [DW-1:0] wdata);
        if (is_dma) begin
            dma_req = 1'b1; dma_we = we; dma_addr = addr; dma_wdata = wdata;
        end else begin
            cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
        end
    endtask

    // One isolated transaction starting from IDLE.
    task automatic do_vec(input int idx, input vec_t v);
        int n;
        @(negedge clk);
        if (!v.we) begin
            if (v.is_dma) dma_sb.push_back(v.exp_rdata);
            else          cpu_sb.push_back(v.exp_rdata);
        end
        drive_req(v.is_dma, v.we, v.addr, v.wdata);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(v.is_dma ? dma_gnt : cpu_gnt) && n < 10);
        check($sformatf("v%0d_gnt_latency", idx), 32'(n), 32'd1);
        check($sformatf("v%0d_owner", idx), 32'(owner_o), 32'(v.is_dma));
        check($sformatf("v%0d_mem_en", idx), 32'(mem_en), 32'd1);
        check($sformatf("v%0d_mem_we", idx), 32'(mem_we), 32'(v.we));
        check($sformatf("v%0d_mem_addr", idx), 32'(mem_addr), 32'(v.addr));
        if (v.we) check($sformatf("v%0d_mem_wdata", idx), 32'(mem_wdata), 32'(v.wdata));
        cpu_req = 1'b0;
        dma_req = 1'b0;
        @(negedge clk);
        check($sformatf("v%0d_cpu_rvalid", idx), 32'(cpu_rvalid), 32'(!v.is_dma && !v.we));
        check($sformatf("v%0d_dma_rvalid", idx), 32'(dma_rvalid), 32'(v.is_dma && !v.we));
        check($sformatf("v%0d_mem_en_drop", idx), 32'(mem_en), 32'd0);
        @(negedge clk);
    endtask

    initial begin
        int exp_starve [10];
        bit exp_order  [10];
        int g, cyc, c_cyc, d_cyc, n, activity;

        vecs[0] = '{1'b0, 1'b0, 16'h0010, 8'h00, 8'hE1};  // CPU read preloaded byte
        vecs[1] = '{1'b1, 1'b1, 16'h0020, 8'h5A, 8'h00};  // DMA write
        vecs[2] = '{1'b0, 1'b0, 16'h0020, 8'h00, 8'h5A};  // CPU readback of DMA write
        vecs[3] = '{1'b1, 1'b1, 16'h00FF, 8'hFE, 8'h00};  // DMA write
        vecs[4] = '{1'b0, 1'b0, 16'h00FF, 8'h00, 8'hFE};  // CPU readback
        vecs[5] = '{1'b1, 1'b0, 16'h0010, 8'h00, 8'hE1};  // DMA read
        vecs[6] = '{1'b0, 1'b1, 16'h1234, 8'h3C, 8'h00};  // CPU write
        vecs[7] = '{1'b1, 1'b0, 16'h1234, 8'h00, 8'h3C};  // DMA readback of CPU write

        exp_starve = '{1, 2, 3, 4, 0, 1, 2, 3, 4, 0};
        exp_order  = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};

        reset = 1'b1;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        dma_req = 1'b0; dma_we = 1'b0; dma_addr = '0; dma_wdata = '0;
        ld_en = 1'b1; ld_addr = 16'h0010; ld_data = 8'hE1;
        repeat (3) @(negedge clk);
        ld_en = 1'b0;

        check("reset_mem_ctrl", {mem_en, mem_we, owner_o}, 32'd0);
        check("reset_mem_addr", 32'(mem_addr), 32'd0);
        check("reset_mem_wdata", 32'(mem_wdata), 32'd0);
        check("reset_gnt_rvalid", {cpu_gnt, dma_gnt, cpu_rvalid, dma_rvalid}, 32'd0);
        check("reset_starve", 32'(dut.starve_cnt_q), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 8; i++) do_vec(i, vecs[i]);

        // Both requesters held: CPU starves DMA for STARVE_LIMIT grants, then DMA is forced in.
        @(negedge clk);
        gnt_log.delete();
        for (int i = 0; i < 8; i++) cpu_sb.push_back(8'hE1);
        for (int i = 0; i < 2; i++) dma_sb.push_back(8'h5A);
        drive_req(1'b0, 1'b0, 16'h0010, 8'h00);
        drive_req(1'b1, 1'b0, 16'h0020, 8'h00);
        g = 0;
        cyc = 0;
        while (g < 10 && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (cpu_gnt || dma_gnt) begin
                check($sformatf("held_starve_%0d", g), 32'(dut.starve_cnt_q), 32'(exp_starve[g]));
                g++;
                if (g == 10) begin
                    cpu_req = 1'b0;
                    dma_req = 1'b0;
                end
            end
        end
        cpu_req = 1'b0;
        dma_req = 1'b0;
        check("held_grant_count", 32'(g), 32'd10);
        repeat (3) @(negedge clk);
        check("held_log_size", 32'(gnt_log.size()), 32'd10);
        for (int k = 0; k < 10; k++) begin
            if (k < gnt_log.size()) check($sformatf("held_order_%0d", k), 32'(gnt_log[k]), 32'(exp_order[k]));
        end

        // Simultaneous single-shot requests: CPU first, DMA at the following ACCESS.
        @(negedge clk);
        gnt_log.delete();
        cpu_sb.push_back(8'hE1);
        dma_sb.push_back(8'hFE);
        drive_req(1'b0, 1'b0, 16'h0010, 8'h00);
        drive_req(1'b1, 1'b0, 16'h00FF, 8'h00);
        c_cyc = -1;
        d_cyc = -1;
        cyc = 0;
        while ((c_cyc < 0 || d_cyc < 0) && cyc < 20) begin
            @(negedge clk);
            cyc++;
            if (cpu_gnt) begin c_cyc = cyc; cpu_req = 1'b0; end
            if (dma_gnt) begin d_cyc = cyc; dma_req = 1'b0; end
        end
        cpu_req = 1'b0;
        dma_req = 1'b0;
        check("simul_cpu_gnt_cycle", 32'(c_cyc), 32'd1);
        check("simul_dma_gnt_cycle", 32'(d_cyc), 32'd3);
        repeat (3) @(negedge clk);
        check("simul_log_size", 32'(gnt_log.size()), 32'd2);
        if (gnt_log.size() == 2) begin
            check("simul_first_cpu", 32'(gnt_log[0]), 32'd0);
            check("simul_second_dma", 32'(gnt_log[1]), 32'd1);
        end

        // Reset during the ACCESS cycle of a CPU read: no rvalid, everything cleared.
        @(negedge clk);
        drive_req(1'b0, 1'b0, 16'h0010, 8'h00);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!cpu_gnt && n < 10);
        check("rst_acc_gnt_seen", 32'(cpu_gnt), 32'd1);
        reset = 1'b1;
        cpu_req = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        check("rst_acc_ctrl", {mem_en, mem_we, owner_o, cpu_gnt, dma_gnt, cpu_rvalid, dma_rvalid}, 32'd0);
        check("rst_acc_addr_data", {mem_addr, mem_wdata}, 32'd0);
        check("rst_acc_starve", 32'(dut.starve_cnt_q), 32'd0);
        activity = 0;
        repeat (3) begin
            @(negedge clk);
            if (mem_en || cpu_gnt || dma_gnt || cpu_rvalid || dma_rvalid) activity++;
        end
        check("rst_acc_idle", 32'(activity), 32'd0);

        // Reset during RESP: rvalid is seen in RESP and gone the next cycle.
        @(negedge clk);
        cpu_sb.push_back(8'h5A);
        drive_req(1'b0, 1'b0, 16'h0020, 8'h00);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!cpu_gnt && n < 10);
        cpu_req = 1'b0;
        @(negedge clk);
        check("rst_resp_rvalid_hi", 32'(cpu_rvalid), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("rst_resp_rvalid_lo", {cpu_rvalid, mem_en, owner_o}, 32'd0);

        repeat (4) @(negedge clk);
        check("cpu_sb_empty", 32'(cpu_sb.size()), 32'd0);
        check("dma_sb_empty", 32'(dma_sb.size()), 32'd0);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
